// File: rtl/maxpool_sched_pkg.sv
// Shared types and elaboration helpers for the maxpool channel sequencer.
package maxpool_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FEED  = 3'd1,
    S_DRAIN = 3'd2,
    S_CLEAR = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned v = value - 1; v != 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/maxpool_sched_wrbuf.sv
// Registered result-capture stage: turns pool results into pooled-buffer writes
// and owns the per-channel result counter.
module maxpool_sched_wrbuf
  import maxpool_sched_pkg::*;
#(
  parameter int unsigned BW         = 20,
  parameter int unsigned CO         = 4,
  parameter int unsigned RES_PER_CH = 144
) (
  input  logic                        clk,
  input  logic                        global_rst_n,
  input  logic                        i_cap_en,
  input  logic                        i_clr,
  input  logic [clog2(CO):0]          i_ch,
  input  logic                        i_mp_valid,
  input  logic [BW-1:0]               i_mp_data,
  output logic [clog2(RES_PER_CH):0]  o_out_cnt,
  output logic                        o_wr_en,
  output logic [clog2(CO):0]          o_wr_ch,
  output logic [clog2(RES_PER_CH):0]  o_wr_addr,
  output logic [BW-1:0]               o_wr_data
);

  localparam int unsigned RW = clog2(RES_PER_CH) + 1;
  localparam logic [RW-1:0] RES_FULL = RW'(RES_PER_CH);

  logic [RW-1:0] out_cnt;
  logic          take;

  // Results past a full map are discarded so the buffer never sees an out-of-range address.
  assign take      = i_cap_en && i_mp_valid && (out_cnt != RES_FULL);
  assign o_out_cnt = out_cnt;

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      out_cnt   <= '0;
      o_wr_en   <= 1'b0;
      o_wr_ch   <= '0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
    end else begin
      o_wr_en <= 1'b0;
      if (i_clr) begin
        out_cnt <= '0;
      end else if (take) begin
        o_wr_en   <= 1'b1;
        o_wr_ch   <= i_ch;
        o_wr_addr <= out_cnt;
        o_wr_data <= i_mp_data;
        out_cnt   <= out_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/maxpool_sched.sv
// Time-shares one maxpool datapath across CO channels: raster-feeds each feature map,
// captures the pooled results, then clears the pool unit before the next channel.
module maxpool_sched
  import maxpool_sched_pkg::*;
#(
  parameter int unsigned BW        = 20,
  parameter int unsigned I_SIZE    = 24,
  parameter int unsigned O_SIZE    = 12,
  parameter int unsigned P_SIZE    = 2,
  parameter int unsigned CO        = 4,
  parameter int unsigned DRAIN_MAX = 64
) (
  input  logic                           clk,
  input  logic                           global_rst_n,
  input  logic                           i_start,
  input  logic                           i_hold,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_err,
  output logic                           o_rd_en,
  output logic [clog2(CO):0]             o_rd_ch,
  output logic [clog2(I_SIZE*I_SIZE):0]  o_rd_addr,
  input  logic [BW-1:0]                  i_rd_data,
  output logic                           o_mp_ce,
  output logic [BW-1:0]                  o_mp_data,
  output logic                           o_mp_rst,
  input  logic [BW-1:0]                  i_mp_data,
  input  logic                           i_mp_valid,
  output logic                           o_wr_en,
  output logic [clog2(CO):0]             o_wr_ch,
  output logic [clog2(O_SIZE*O_SIZE):0]  o_wr_addr,
  output logic [BW-1:0]                  o_wr_data
);

  localparam int unsigned PIX_PER_CH = I_SIZE * I_SIZE;
  localparam int unsigned RES_PER_CH = O_SIZE * O_SIZE;
  localparam int unsigned CW = clog2(CO) + 1;
  localparam int unsigned AW = clog2(PIX_PER_CH) + 1;
  localparam int unsigned RW = clog2(RES_PER_CH) + 1;
  localparam int unsigned DW = clog2(DRAIN_MAX) + 1;
  localparam logic [CW-1:0] CH_LAST    = CW'(CO - 1);
  localparam logic [AW-1:0] PIX_LAST   = AW'(PIX_PER_CH - 1);
  localparam logic [RW-1:0] RES_FULL   = RW'(RES_PER_CH);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_MAX - 1);

  if (O_SIZE * P_SIZE != I_SIZE) begin : g_bad_geometry
    $error("maxpool_sched: O_SIZE must equal I_SIZE/P_SIZE");
  end

  state_t        state, state_nxt;
  logic [CW-1:0] ch;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] drain_cnt;
  logic [RW-1:0] out_cnt;
  logic          err, rd_en_d, cap_en, cnt_clr;
  logic          rd_last, res_full, drain_to;

  assign rd_last  = (rd_addr == PIX_LAST);
  assign res_full = (out_cnt == RES_FULL);
  assign drain_to = (drain_cnt == DRAIN_LAST);

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) state <= S_IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_start) state_nxt = S_FEED;
      S_FEED:  if (!i_hold && rd_last) state_nxt = S_DRAIN;
      S_DRAIN: if (res_full || drain_to) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = (ch == CH_LAST) ? S_DONE : S_FEED;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_rd_en  = 1'b0;
    o_mp_rst = 1'b0;
    o_done   = 1'b0;
    cap_en   = 1'b0;
    cnt_clr  = 1'b0;
    o_busy   = (state != S_IDLE);
    case (state)
      S_IDLE:  cnt_clr = i_start;
      S_FEED:  begin o_rd_en = !i_hold; cap_en = 1'b1; end
      S_DRAIN: cap_en = 1'b1;
      S_CLEAR: begin o_mp_rst = 1'b1; cnt_clr = 1'b1; end
      S_DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

  // drain_cnt runs only while in DRAIN, so the timeout fires after exactly DRAIN_MAX cycles there.
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      ch        <= '0;
      rd_addr   <= '0;
      drain_cnt <= '0;
      err       <= 1'b0;
      rd_en_d   <= 1'b0;
    end else begin
      rd_en_d   <= o_rd_en;
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
      case (state)
        S_IDLE:  if (i_start) begin err <= 1'b0; ch <= '0; rd_addr <= '0; end
        S_FEED:  if (o_rd_en) rd_addr <= rd_addr + 1'b1;
        S_DRAIN: if (!res_full && drain_to) err <= 1'b1;
        S_CLEAR: if (ch != CH_LAST) begin ch <= ch + 1'b1; rd_addr <= '0; end
        default: ;
      endcase
    end
  end

  assign o_rd_ch   = ch;
  assign o_rd_addr = rd_addr;
  assign o_err     = err;
  assign o_mp_ce   = rd_en_d;
  assign o_mp_data = rd_en_d ? i_rd_data : '0;

  maxpool_sched_wrbuf #(
    .BW         (BW),
    .CO         (CO),
    .RES_PER_CH (RES_PER_CH)
  ) u_wrbuf (
    .clk          (clk),
    .global_rst_n (global_rst_n),
    .i_cap_en     (cap_en),
    .i_clr        (cnt_clr),
    .i_ch         (ch),
    .i_mp_valid   (i_mp_valid),
    .i_mp_data    (i_mp_data),
    .o_out_cnt    (out_cnt),
    .o_wr_en      (o_wr_en),
    .o_wr_ch      (o_wr_ch),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data)
  );

endmodule
